// File: rtl/flappy_game_sequencer_pkg.sv
// Shared definitions for the Flappy game sequencer: state encodings,
// default divider constants and small arithmetic helpers.
package flappy_game_sequencer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_LOST = 2'd2;
    localparam logic [1:0] ST_WIN  = 2'd3;

    localparam int unsigned DEF_PIPE_DIV        = 32'd524288;
    localparam int unsigned DEF_BIRD_DIV        = 32'd1048576;
    localparam int unsigned DEF_FLASH_DIV       = 32'd4194304;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd500000;
    localparam int unsigned DEF_WIN_SCORE       = 32'd10;

    function automatic logic [3:0] max_u4(input logic [3:0] a, input logic [3:0] b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/flappy_game_sequencer_btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter and a
// single-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce
    import flappy_game_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Stability counter: any cycle where the input agrees with the level restarts it
    always_comb begin
        level_d = level_q;
        cnt_d   = {CW{1'b0}};
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = {CW{1'b0}};
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Rising edge of the accepted level, so a held button yields one pulse
    always_comb begin
        press_d = level_q & ~level_prev_q;
    end

    // Synchronizer, debounce state and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= {CW{1'b0}};
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/flappy_game_sequencer.sv
// Flappy game controller: debounced Start/Ack, IDLE/PLAY/LOST/WIN FSM,
// pipe/bird tick prescalers, lose/win flash and high-score register.
module flappy_game_sequencer
    import flappy_game_sequencer_pkg::*;
#(
    parameter int unsigned PIPE_DIV        = DEF_PIPE_DIV,
    parameter int unsigned BIRD_DIV        = DEF_BIRD_DIV,
    parameter int unsigned FLASH_DIV       = DEF_FLASH_DIV,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned WIN_SCORE       = DEF_WIN_SCORE
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       BtnC,
    input  logic       BtnD,
    input  logic       collision,
    input  logic [3:0] score,
    output logic       start_pulse,
    output logic       ack_pulse,
    output logic       stop,
    output logic       pipe_tick,
    output logic       bird_tick,
    output logic       flash,
    output logic [1:0] state,
    output logic [3:0] high_score
);

    localparam int unsigned PW = (PIPE_DIV  > 32'd1) ? $clog2(PIPE_DIV)  : 32'd1;
    localparam int unsigned BW = (BIRD_DIV  > 32'd1) ? $clog2(BIRD_DIV)  : 32'd1;
    localparam int unsigned FW = (FLASH_DIV > 32'd1) ? $clog2(FLASH_DIV) : 32'd1;

    localparam logic [PW-1:0] PIPE_LAST  = PW'(PIPE_DIV  - 32'd1);
    localparam logic [BW-1:0] BIRD_LAST  = BW'(BIRD_DIV  - 32'd1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 32'd1);
    localparam logic [3:0]    WIN_VAL    = 4'(WIN_SCORE);

    logic          btnc_press;
    logic          btnd_press;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic          start_q;
    logic          start_d;
    logic          ack_q;
    logic          ack_d;
    logic          stop_q;
    logic          stop_d;
    logic [3:0]    high_score_q;
    logic [3:0]    high_score_d;

    logic          stay_play;
    logic          stay_lost;

    logic [PW-1:0] pipe_cnt_q;
    logic [PW-1:0] pipe_cnt_d;
    logic          pipe_tick_q;
    logic          pipe_tick_d;
    logic [BW-1:0] bird_cnt_q;
    logic [BW-1:0] bird_cnt_d;
    logic          bird_tick_q;
    logic          bird_tick_d;
    logic [FW-1:0] flash_cnt_q;
    logic [FW-1:0] flash_cnt_d;
    logic          flash_q;
    logic          flash_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_start (
        .clk     (Clk),
        .rst     (reset),
        .btn_raw (BtnC),
        .press   (btnc_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_ack (
        .clk     (Clk),
        .rst     (reset),
        .btn_raw (BtnD),
        .press   (btnd_press)
    );

    // Game FSM; collision has priority over reaching the winning score
    always_comb begin
        state_d      = state_q;
        start_d      = 1'b0;
        ack_d        = 1'b0;
        high_score_d = high_score_q;
        case (state_q)
            ST_IDLE: begin
                if (btnc_press) begin
                    state_d = ST_PLAY;
                    start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (collision) begin
                    state_d      = ST_LOST;
                    high_score_d = max_u4(high_score_q, score);
                end else if (score == WIN_VAL) begin
                    state_d      = ST_WIN;
                    high_score_d = max_u4(high_score_q, score);
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_LOST, ST_WIN: begin
                if (btnd_press) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        stop_d    = (state_d != ST_PLAY);
        stay_play = (state_q == ST_PLAY) && (state_d == ST_PLAY);
        stay_lost = (state_q == ST_LOST) && (state_d == ST_LOST);
    end

    // Tick prescalers; cleared outside PLAY and on the exit cycle so no late tick escapes
    always_comb begin
        pipe_cnt_d  = {PW{1'b0}};
        pipe_tick_d = 1'b0;
        bird_cnt_d  = {BW{1'b0}};
        bird_tick_d = 1'b0;
        if (stay_play) begin
            if (pipe_cnt_q == PIPE_LAST) begin
                pipe_cnt_d  = {PW{1'b0}};
                pipe_tick_d = 1'b1;
            end else begin
                pipe_cnt_d  = pipe_cnt_q + PW'(1);
                pipe_tick_d = 1'b0;
            end
            if (bird_cnt_q == BIRD_LAST) begin
                bird_cnt_d  = {BW{1'b0}};
                bird_tick_d = 1'b1;
            end else begin
                bird_cnt_d  = bird_cnt_q + BW'(1);
                bird_tick_d = 1'b0;
            end
        end else begin
            pipe_cnt_d  = {PW{1'b0}};
            bird_cnt_d  = {BW{1'b0}};
        end
    end

    // Flash overlay: steady in WIN, blinking in LOST, dark elsewhere
    always_comb begin
        flash_cnt_d = {FW{1'b0}};
        flash_d     = 1'b0;
        if (state_d == ST_WIN) begin
            flash_d = 1'b1;
        end else if (stay_lost) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_cnt_d = {FW{1'b0}};
                flash_d     = ~flash_q;
            end else begin
                flash_cnt_d = flash_cnt_q + FW'(1);
                flash_d     = flash_q;
            end
        end else begin
            flash_d = 1'b0;
        end
    end

    // All controller state and outputs are registered here
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            ack_q        <= 1'b0;
            stop_q       <= 1'b1;
            high_score_q <= 4'd0;
            pipe_cnt_q   <= {PW{1'b0}};
            pipe_tick_q  <= 1'b0;
            bird_cnt_q   <= {BW{1'b0}};
            bird_tick_q  <= 1'b0;
            flash_cnt_q  <= {FW{1'b0}};
            flash_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            ack_q        <= ack_d;
            stop_q       <= stop_d;
            high_score_q <= high_score_d;
            pipe_cnt_q   <= pipe_cnt_d;
            pipe_tick_q  <= pipe_tick_d;
            bird_cnt_q   <= bird_cnt_d;
            bird_tick_q  <= bird_tick_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_q      <= flash_d;
        end
    end

    assign state       = state_q;
    assign start_pulse = start_q;
    assign ack_pulse   = ack_q;
    assign stop        = stop_q;
    assign high_score  = high_score_q;
    assign pipe_tick   = pipe_tick_q;
    assign bird_tick   = bird_tick_q;
    assign flash       = flash_q;

endmodule

// File: tb/tb_flappy_game_sequencer.sv
// Self-checking bench for flappy_game_sequencer: expected post-pulse states are
// queued as buttons are driven and popped when start/ack pulses appear.
module tb_flappy_game_sequencer;
    import flappy_game_sequencer_pkg::*;

    localparam int unsigned T_DEB   = 32'd4;
    localparam int unsigned T_PIPE  = 32'd8;
    localparam int unsigned T_BIRD  = 32'd16;
    localparam int unsigned T_FLASH = 32'd4;
    localparam int unsigned T_WIN   = 32'd10;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnc;
    logic       btnd;
    logic       collision;
    logic [3:0] score;
    logic       start_pulse;
    logic       ack_pulse;
    logic       stop;
    logic       pipe_tick;
    logic       bird_tick;
    logic       flash;
    logic [1:0] state;
    logic [3:0] high_score;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cnt = 0;
    int         ack_cnt = 0;
    int         bad_ticks = 0;
    int         entry_cyc = 0;
    int         first_pipe = -1;
    int         first_bird = -1;
    bit         pipe_seen = 1'b0;
    bit         bird_seen = 1'b0;
    logic [1:0] prev_state = 2'd0;
    logic [1:0] sb_q[$];

    flappy_game_sequencer #(
        .PIPE_DIV        (T_PIPE),
        .BIRD_DIV        (T_BIRD),
        .FLASH_DIV       (T_FLASH),
        .DEBOUNCE_CYCLES (T_DEB),
        .WIN_SCORE       (T_WIN)
    ) dut (
        .Clk         (clk),
        .reset       (reset),
        .BtnC        (btnc),
        .BtnD        (btnd),
        .collision   (collision),
        .score       (score),
        .start_pulse (start_pulse),
        .ack_pulse   (ack_pulse),
        .stop        (stop),
        .pipe_tick   (pipe_tick),
        .bird_tick   (bird_tick),
        .flash       (flash),
        .state       (state),
        .high_score  (high_score)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one cycle, sample on the falling edge and update the scoreboard/monitors
    task automatic tick();
        logic [1:0] e;
        @(negedge clk);
        cyc++;
        if (!reset) begin
            if (start_pulse) start_cnt++;
            if (ack_pulse) ack_cnt++;
            if (start_pulse || ack_pulse) begin
                check_val("sb_pending", (sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_val("pulse_state", state, e);
                    check_val("pulse_stop", stop, (e != ST_PLAY));
                    if (ack_pulse) check_val("ack_flash", flash, 0);
                end
            end
            if ((pipe_tick || bird_tick) && state != ST_PLAY) bad_ticks++;
            if (state == ST_PLAY && prev_state != ST_PLAY) begin
                entry_cyc = cyc;
                pipe_seen = 1'b0;
                bird_seen = 1'b0;
            end
            if (state == ST_PLAY && pipe_tick && !pipe_seen) begin
                first_pipe = cyc - entry_cyc;
                pipe_seen  = 1'b1;
            end
            if (state == ST_PLAY && bird_tick && !bird_seen) begin
                first_bird = cyc - entry_cyc;
                bird_seen  = 1'b1;
            end
            prev_state = state;
        end else begin
            prev_state = ST_IDLE;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input bit ack_btn);
        if (ack_btn) btnd = 1'b1; else btnc = 1'b1;
        cycles(10);
        btnd = 1'b0;
        btnc = 1'b0;
        cycles(8);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_state"}, state, ST_IDLE);
        check_val({pfx, "_stop"}, stop, 1);
        check_val({pfx, "_start"}, start_pulse, 0);
        check_val({pfx, "_ack"}, ack_pulse, 0);
        check_val({pfx, "_pipe"}, pipe_tick, 0);
        check_val({pfx, "_bird"}, bird_tick, 0);
        check_val({pfx, "_flash"}, flash, 0);
        check_val({pfx, "_hs"}, high_score, 0);
    endtask

    initial begin
        reset = 1'b1;
        btnc = 1'b0;
        btnd = 1'b0;
        collision = 1'b0;
        score = 4'd0;
        cycles(3);
        reset = 1'b0;
        tick();
        check_reset_vals("rst");

        // Bouncy start: 1-0-1 then held high
        sb_q.push_back(ST_PLAY);
        btnc = 1'b1; tick();
        btnc = 1'b0; tick();
        btnc = 1'b1; cycles(20);
        btnc = 1'b0; cycles(20);
        check_val("start_once", start_cnt, 1);
        check_val("play_state", state, ST_PLAY);
        check_val("play_stop", stop, 0);
        check_val("first_pipe", first_pipe, T_PIPE);
        check_val("first_bird", first_bird, T_BIRD);

        // Collision at score 5
        score = 4'd5;
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check_val("lost_state", state, ST_LOST);
        check_val("lost_stop", stop, 1);
        check_val("lost_hs", high_score, 5);
        check_val("lost_pipe", pipe_tick, 0);
        check_val("lost_bird", bird_tick, 0);
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick();
            check_val("flash_lost", flash, ((k - 1) / 4) % 2);
        end

        // Acknowledge back to IDLE, then restart
        sb_q.push_back(ST_IDLE);
        press(1'b1);
        check_val("ack_once", ack_cnt, 1);
        check_val("idle_state", state, ST_IDLE);
        check_val("idle_flash", flash, 0);
        check_val("idle_stop", stop, 1);
        score = 4'd0;
        sb_q.push_back(ST_PLAY);
        press(1'b0);
        check_val("start_twice", start_cnt, 2);
        check_val("replay_state", state, ST_PLAY);

        // Score steps up to the win value
        score = 4'd8;  tick();
        score = 4'd9;  tick();
        check_val("pre_win_state", state, ST_PLAY);
        score = 4'd10; tick();
        check_val("win_state", state, ST_WIN);
        check_val("win_hs", high_score, 10);
        check_val("win_stop", stop, 1);
        for (int k = 0; k < 8; k++) begin
            check_val("flash_win", flash, 1);
            tick();
        end

        // Collision and win score in the same cycle: LOST has priority
        sb_q.push_back(ST_IDLE);
        press(1'b1);
        score = 4'd0;
        sb_q.push_back(ST_PLAY);
        press(1'b0);
        collision = 1'b1;
        score = 4'd10;
        tick();
        collision = 1'b0;
        score = 4'd0;
        check_val("tie_state", state, ST_LOST);
        check_val("tie_hs", high_score, 10);

        // Fresh start, earn a high score of 7, then reset mid-PLAY
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_val("rst2_hs", high_score, 0);
        sb_q.push_back(ST_PLAY);
        press(1'b0);
        score = 4'd7;
        collision = 1'b1;
        tick();
        collision = 1'b0;
        score = 4'd0;
        check_val("hs7", high_score, 7);
        sb_q.push_back(ST_IDLE);
        press(1'b1);
        sb_q.push_back(ST_PLAY);
        press(1'b0);
        cycles(5);
        check_val("pre_rst_play", state, ST_PLAY);
        check_val("pre_rst_hs", high_score, 7);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        tick();
        reset = 1'b0;

        check_val("no_stray_ticks", bad_ticks, 0);
        check_val("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
